ram_fifo_ctrl: RTL and testbench

//  Sequences the 4096x8 single-clock write/read RAM as a circular FIFO between an upstream

---
 rtl/ram_fifo_ctrl_pkg.sv | 19 +
 rtl/ram_fifo_ctrl_if.sv | 32 +++
 rtl/ram_fifo_ctrl_out_buf.sv | 76 +++++++
 rtl/ram_fifo_ctrl.sv | 88 ++++++++
 tb/tb_ram_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and types for the RAM-backed byte FIFO controller.
// Level width covers DEPTH words in RAM plus the read pipeline.
package ram_fifo_pkg;

    localparam int AW_DEF   = 12;
    localparam int DW_DEF   = 8;
    localparam int OB_DEPTH = 2;

    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } ob_state_e;

    function automatic int lvl_w(input int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Upstream/downstream valid-ready byte stream bundle.
// slave = the FIFO, master = producer/consumer side.
interface ram_fifo_ctrl_if #(
    parameter int DW = ram_fifo_pkg::DW_DEF
);

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/ram_fifo_ctrl_out_buf.sv
// Two-entry registered output buffer that absorbs the RAM read latency.
// Head entry drives out_data; second entry only fills while head is held.
module fifo_out_buf
    import ram_fifo_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          pop_i,
    output logic [1:0]    ob_cnt_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o
);

    ob_state_e     st_q;
    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic          vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= OB_EMPTY;
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= 1'b0;
        end else if (flush_i) begin
            st_q  <= OB_EMPTY;
            vld_q <= 1'b0;
        end else begin
            unique case (st_q)
                OB_EMPTY: begin
                    if (load_i) begin
                        head_q <= load_data_i;
                        st_q   <= OB_ONE;
                        vld_q  <= 1'b1;
                    end
                end
                OB_ONE: begin
                    if (load_i && pop_i) begin
                        head_q <= load_data_i;
                    end else if (load_i) begin
                        tail_q <= load_data_i;
                        st_q   <= OB_TWO;
                    end else if (pop_i) begin
                        st_q  <= OB_EMPTY;
                        vld_q <= 1'b0;
                    end
                end
                OB_TWO: begin
                    // issue logic never loads a full buffer without a pop
                    if (pop_i) begin
                        head_q <= tail_q;
                        if (load_i) begin
                            tail_q <= load_data_i;
                        end else begin
                            st_q <= OB_ONE;
                        end
                    end
                end
                default: begin
                    st_q  <= OB_EMPTY;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign ob_cnt_o    = st_q;
    assign out_valid_o = vld_q;
    assign out_data_o  = head_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Circular FIFO sequencer for a single-clock 2^AW x DW RAM with 1-cycle read.
// Owns RAM pins, pointers and read issue; output buffering is in fifo_out_buf.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    ram_fifo_ctrl_if.slave        bus,
    output logic [lvl_w(AW)-1:0]  level,
    output logic                  ram_we,
    output logic [DW-1:0]         ram_d,
    output logic [AW-1:0]         ram_waddr,
    output logic [AW-1:0]         ram_raddr,
    input  logic [DW-1:0]         ram_q
);

    localparam int            LW    = lvl_w(AW);
    localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          infl_q, infl_d;
    logic          push, pop, rd;
    logic [1:0]    ob_cnt;
    logic [2:0]    occ;

    assign bus.in_ready = (cnt_q != DEPTH) & ~flush;
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    // words already headed for the buffer, counting a slot freed by this pop
    assign occ = {1'b0, ob_cnt} + {2'b0, infl_q};
    assign rd  = (cnt_q != '0) & ~flush & (occ < (3'd2 + {2'b0, pop}));

    always_comb begin
        wptr_d = wptr_q + {{(AW-1){1'b0}}, push};
        rptr_d = rptr_q + {{(AW-1){1'b0}}, rd};
        cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, rd};
        infl_d = rd;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            infl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            infl_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
        end
    end

    fifo_out_buf #(
        .DW (DW)
    ) u_ob (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .load_i      (infl_q),
        .load_data_i (ram_q),
        .pop_i       (pop),
        .ob_cnt_o    (ob_cnt),
        .out_valid_o (bus.out_valid),
        .out_data_o  (bus.out_data)
    );

    assign ram_we    = push & rst_n;
    assign ram_d     = bus.in_data;
    assign ram_waddr = wptr_q;
    assign ram_raddr = rptr_q;

    assign level = LW'(cnt_q) + LW'(infl_q) + LW'(ob_cnt);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Random and directed stimulus against a queue model of the FIFO,
// with a behavioural 4096x8 RAM behind the ram_* pins.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    localparam int DEPTH = 4096;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic [13:0] level;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;
    logic [11:0] ram_waddr;
    logic [11:0] ram_raddr;
    logic [7:0]  mem [0:DEPTH-1];

    ram_fifo_ctrl_if bus ();

    ram_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .level     (level),
        .ram_we    (ram_we),
        .ram_d     (ram_d),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    // a same-cycle read of the slot being written returns junk
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_d;
        if (ram_we && ram_waddr == ram_raddr) ram_q <= ~ram_d;
        else ram_q <= mem[ram_raddr];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic [7:0] q[$];
    int         wcnt  = 0;
    int         stall = 0;
    bit         hold  = 0;
    logic [7:0] held  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_level", level, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_ram_we", ram_we, 0);
            q.delete();
            wcnt  = 0;
            stall = 0;
            hold  = 0;
        end else begin
            bit push, pop;
            chk("level", level, q.size());
            if (bus.out_valid)
                chk("head", bus.out_data,
                    (q.size() != 0) ? longint'(q[0]) : -1);
            if (hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, held);
            end
            if (q.size() < DEPTH)
                chk("in_ready", bus.in_ready, !flush);
            else if (q.size() == DEPTH + 2)
                chk("full_ready", bus.in_ready, 0);
            stall = (q.size() != 0 && !bus.out_valid) ? stall + 1 : 0;
            chk("stall_le2", stall <= 2, 1);
            push = bus.in_valid && bus.in_ready;
            pop  = bus.out_valid && bus.out_ready && !flush;
            chk("ram_we", ram_we, push);
            if (push) chk("ram_d", ram_d, bus.in_data);
            chk("ram_waddr", ram_waddr, wcnt % DEPTH);
            hold = bus.out_valid && !bus.out_ready && !flush;
            held = bus.out_data;
            if (flush) begin
                q.delete();
                wcnt = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back(bus.in_data);
                    wcnt++;
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10000 && level != 0; i++) step();
        @(negedge clk);
        chk("drain_empty", level, 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int acc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_level0", level, 0);
        chk("t1_valid0", bus.out_valid, 0);
        chk("t1_ready1", bus.in_ready, 1);

        // single word latency
        step();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        @(negedge clk);
        chk("t1_we", ram_we, 1);
        chk("t1_waddr", ram_waddr, 0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid_n1", bus.out_valid, 0);
        @(negedge clk);
        chk("t1_valid_n2", bus.out_valid, 0);
        @(negedge clk);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 8'hA5);
        chk("t1_level", level, 1);
        drain();

        // streaming at full rate
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            @(negedge clk);
            if (i >= 3) begin
                chk("t2_no_bubble", bus.out_valid, 1);
                chk("t2_level_2to3", level >= 2 && level <= 3, 1);
            end
        end
        step();
        drain();

        // fill to capacity with consumer stalled
        for (int i = 0; i < 4099; i++) begin
            step();
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i) ^ 8'h5A;
        end
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_full_level", level, 4098);
        chk("t3_full_ready", bus.in_ready, 0);
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t3_pop_level", level, 4097);
        drain();

        // random traffic across pointer wrap
        acc = 0;
        for (int i = 0; i < 40000 && acc < 5000; i++) begin
            step();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
        end
        chk("t4_accepted", acc, 5000);
        step();
        drain();

        // flush with a read in flight
        for (int i = 0; i < 11; i++) begin
            step();
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h10 + 8'(i);
        end
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("t5_level_pre", level, 10);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_valid0", bus.out_valid, 0);
        chk("t5_level0", level, 0);
        chk("t5_ready1", bus.in_ready, 1);
        chk("t5_raddr0", ram_raddr, 0);
        step();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.out_valid; i++) step();
        @(negedge clk);
        chk("t5_first_valid", bus.out_valid, 1);
        chk("t5_first_data", bus.out_data, 8'h3C);
        drain();

        // asynchronous reset mid-stream
        for (int i = 0; i < 30; i++) begin
            step();
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_valid0", bus.out_valid, 0);
        chk("t6_level0", level, 0);
        chk("t6_we0", ram_we, 0);
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_level_after", level, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
